// File: rtl/ext_bus_router.sv
// ext_bus_router: routes one CPU bus master to NUM_CH slave channels chosen by the top address bits.
// Accesses are registered, with a per-access timeout and an error response for unmapped targets.
`default_nettype none

module ext_bus_router #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int NUM_CH    = 4,
   parameter int SEL_W     = 3,
   parameter int CH_ADDR_W = 21,
   parameter int TIMEOUT   = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        addr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     re_i,
   input  logic                     we_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     needWait_o,
   output logic                     err_o,
   output logic [CH_ADDR_W-1:0]     ch_addr_o,
   output logic [DATA_W-1:0]        ch_wdata_o,
   input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
   output logic [NUM_CH-1:0]        ch_re_o,
   output logic [NUM_CH-1:0]        ch_we_o,
   input  logic [NUM_CH-1:0]        ch_needWait_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SEL_W-1:0]      r_sel;
   logic                  r_wr;
   logic [CNT_W-1:0]      r_cnt;
   logic [CH_ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_err;
   logic [NUM_CH-1:0]     r_re;
   logic [NUM_CH-1:0]     r_we;

   logic                  w_req;
   logic [SEL_W-1:0]      w_sel;
   logic                  w_mapped;
   logic [NUM_CH-1:0]     w_onehot;
   logic                  w_ch_wait;
   logic [DATA_W-1:0]     w_ch_rdata;
   logic                  w_tmo;

   assign w_req      = re_i | we_i;
   assign w_sel      = addr_i[ADDR_W-1 -: SEL_W];
   assign w_mapped   = ({1'b0, w_sel} < (SEL_W+1)'(NUM_CH));
   assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign needWait_o = w_req & (r_state != S_DONE);

   always_comb begin
      w_onehot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_onehot[k] = (w_sel == SEL_W'(k));
      end
   end

   // r_sel is always a mapped channel while in ACCESS, so the mux needs no default branch.
   always_comb begin
      w_ch_wait  = 1'b0;
      w_ch_rdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_sel == SEL_W'(k)) begin
            w_ch_wait  = ch_needWait_i[k];
            w_ch_rdata = ch_rdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_state_nxt = w_mapped ? S_ACCESS : S_DONE;
         end
         S_ACCESS: begin
            if (!w_req)                   w_state_nxt = S_IDLE;
            else if (!w_ch_wait || w_tmo) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel   <= '0;
         r_wr    <= 1'b0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_re    <= '0;
         r_we    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_sel   <= w_sel;
                  r_wr    <= we_i;
                  r_addr  <= addr_i[CH_ADDR_W-1:0];
                  r_wdata <= wdata_i;
                  r_cnt   <= '0;
                  if (w_mapped) begin
                     r_re <= we_i ? '0 : w_onehot;
                     r_we <= we_i ? w_onehot : '0;
                  end else begin
                     r_err   <= 1'b1;
                     r_rdata <= '1;
                  end
               end
            end
            S_ACCESS: begin
               if (!w_req) begin
                  r_re <= '0;
                  r_we <= '0;
               end else if (!w_ch_wait) begin
                  r_re  <= '0;
                  r_we  <= '0;
                  r_err <= 1'b0;
                  if (!r_wr) r_rdata <= w_ch_rdata;
               end else if (w_tmo) begin
                  r_re    <= '0;
                  r_we    <= '0;
                  r_err   <= 1'b1;
                  r_rdata <= '1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_re <= '0;
               r_we <= '0;
            end
         endcase
      end
   end

   assign rdata_o    = r_rdata;
   assign err_o      = r_err;
   assign ch_addr_o  = r_addr;
   assign ch_wdata_o = r_wdata;
   assign ch_re_o    = r_re;
   assign ch_we_o    = r_we;

endmodule

`default_nettype wire

// File: doc/ext_bus_router.md
Name: ext_bus_router

Overview:
Parametrised successor to the fixed four-target external memory interface. It routes one CPU bus master (addr/re/we/needWait) to NUM_CH slave channels selected by the top address bits. Each transaction is registered and passed through a small FSM, with per-access timeout and an error response for unmapped or hung accesses. It sits between nqcpu and the flash, DRAM, SRAM and peripheral blocks. Split read and write data replace the tristate data bus.

Parameters:
ADDR_W, 24, CPU address width
DATA_W, 16, data width
NUM_CH, 4, number of slave channels (1..2**SEL_W)
SEL_W, 3, address MSBs used as the channel index
CH_ADDR_W, 21, address bits forwarded to a slave (CH_ADDR_W <= ADDR_W-SEL_W)
TIMEOUT, 255, maximum ACCESS cycles before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
addr_i  in  ADDR_W  CPU address, held stable while needWait_o=1
wdata_i  in  DATA_W  CPU write data
re_i  in  1  CPU read request
we_i  in  1  CPU write request
rdata_o  out  DATA_W  registered read data, valid while needWait_o=0 in DONE
needWait_o  out  1  stall to CPU
err_o  out  1  error flag, valid with the completion cycle
ch_addr_o  out  CH_ADDR_W  registered slave address, shared by all channels
ch_wdata_o  out  DATA_W  registered write data, shared by all channels
ch_rdata_i  in  NUM_CH*DATA_W  slave read data, channel k at [k*DATA_W +: DATA_W]
ch_re_o  out  NUM_CH  one-hot read strobe
ch_we_o  out  NUM_CH  one-hot write strobe
ch_needWait_i  in  NUM_CH  slave stall

Behaviour:
- Reset (async, immediate): state=IDLE; ch_re_o=0, ch_we_o=0, ch_addr_o=0, ch_wdata_o=0, rdata_o=0, err_o=0, timeout count=0. An in-flight access is dropped silently.
- sel = addr_i[ADDR_W-1 -: SEL_W]. sel >= NUM_CH means unmapped.
- req = re_i | we_i. If both are set, the access is a write (we_i wins).
- needWait_o = req & (state != DONE) is combinational. It is 0 whenever req=0.
- FSM:
  - IDLE:
    - On req, latch addr_i[CH_ADDR_W-1:0], wdata_i, op and sel.
    - Mapped: go to ACCESS.
    - Unmapped: go to DONE with err=1 and rdata=all-ones.
  - ACCESS:
    - Drive ch_re_o[sel] or ch_we_o[sel] high; all other strobes stay 0.
    - Each cycle, if ch_needWait_i[sel]=0: capture ch_rdata_i[sel] into rdata_o (reads only; writes leave rdata_o unchanged), set err=0, go to DONE.
    - Otherwise increment the count.
    - If the count reaches TIMEOUT-1 while the slave still waits: set err=1, rdata_o=all-ones, go to DONE.
    - If req drops mid-ACCESS: abort to IDLE, clear strobes, err unchanged.
  - DONE:
    - Strobes are 0 and needWait_o=0 for exactly one cycle.
    - Next state is IDLE unconditionally. A request held or newly presented is accepted in the following IDLE cycle.
- Strobes and the timeout count are registered. Strobes go high on the cycle after entry to ACCESS and drop on the DONE entry edge.
- Zero-wait slave latency: request at cycle N, strobe during N+1, needWait_o=0 during N+2. Total 3 cycles, i.e. 2 stall cycles.
- err_o holds its value until the next completion. It is meaningful only in the DONE cycle.
- rdata_o holds its value until the next read completion or error.
- Timeout counter width is clog2(TIMEOUT+1). It is cleared on every IDLE->ACCESS transition.

Test Plan:
- Zero-wait read:
  - Stimulus: NUM_CH=4, ch2 returns 16'hBEEF with needWait=0; re_i=1, addr=24'h4000_12.
  - Required: ch_re_o=4'b0100 for 1 cycle, ch_addr_o=21'h000012, needWait_o low on cycle 3, rdata_o=BEEF, err_o=0.
- Wait-stated write:
  - Stimulus: ch1 holds needWait=1 for 5 cycles; we_i=1, addr=24'h200034, wdata=16'h1234.
  - Required: ch_we_o[1]=1 for 6 cycles, ch_wdata_o=1234, completion on cycle 8, err_o=0, rdata_o unchanged.
- Unmapped:
  - Stimulus: addr=24'hE00000 (sel=7).
  - Required: no strobe ever, completion in 2 cycles, err_o=1, rdata_o=FFFF.
- Timeout:
  - Stimulus: TIMEOUT=8, ch0 needWait stuck at 1.
  - Required: strobe high for exactly 8 cycles, then DONE with err_o=1, rdata=FFFF; the next read to a good channel completes with err_o=0.
- Reset mid-access:
  - Stimulus: assert rst asynchronously during ACCESS with ch3 stalled.
  - Required: ch_re_o/ch_we_o=0 and state IDLE before the next clock edge, all outputs 0; after release, a fresh read completes normally.
- Back-to-back with re_i&we_i:
  - Stimulus: hold both re_i and we_i over two sequential accesses.
  - Required: both are executed as writes, and the accesses are separated by exactly one IDLE cycle after each DONE.
